// File: rtl/pio_gpio_ctrl.sv
// Avalon-MM GPIO slave: per-bit direction, atomic set/clear, timed pulses,
// synchronised inputs with edge capture and a maskable level interrupt.
module pio_gpio_ctrl #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter int unsigned      PULSE_LEN   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam int unsigned    CW         = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0]  PULSE_LOAD = CW'(PULSE_LEN);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE   = 3'd6;

  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] wd;
  logic             unused_writedata;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] pulse_bits;
  logic [CW-1:0]    pulse_cnt;
  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev_in;

  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] data_nx;
  logic [WIDTH-1:0] dir_nx;
  logic [WIDTH-1:0] mask_nx;
  logic [WIDTH-1:0] cap_nx;
  logic [WIDTH-1:0] pulse_bits_nx;
  logic [CW-1:0]    pulse_cnt_nx;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] pulse_wd;
  logic [WIDTH-1:0] expire_clr;
  logic [31:0]      rdata_nx;

  assign wr               = chipselect & ~write_n;
  assign rd               = chipselect & ~read_n;
  assign wd               = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;
  assign out_port         = data_out;
  assign oe               = dir;

  always_comb begin
    detect = '0;
    if (EDGE_TYPE == 0)      detect = sync_in & ~prev_in;
    else if (EDGE_TYPE == 1) detect = ~sync_in & prev_in;
    else                     detect = sync_in ^ prev_in;
  end

  // Bus write is applied first; pulse expiry then clears only bits still owned by the pulse.
  always_comb begin
    data_nx       = data_out;
    dir_nx        = dir;
    mask_nx       = irq_mask;
    pulse_bits_nx = pulse_bits;
    pulse_cnt_nx  = pulse_cnt;
    w1c           = '0;
    pulse_wd      = '0;
    expire_clr    = '0;
    if (pulse_cnt != '0) pulse_cnt_nx = pulse_cnt - CNT_ONE;
    if (wr) begin
      case (address)
        ADDR_DATA: begin
          data_nx       = wd;
          pulse_bits_nx = '0;
          pulse_cnt_nx  = '0;
        end
        ADDR_DIR:     dir_nx = wd;
        ADDR_IRQMASK: mask_nx = wd;
        ADDR_EDGECAP: w1c = wd;
        ADDR_OUTSET: begin
          data_nx       = data_out | wd;
          pulse_bits_nx = pulse_bits & ~wd;
        end
        ADDR_OUTCLR: begin
          data_nx       = data_out & ~wd;
          pulse_bits_nx = pulse_bits & ~wd;
        end
        ADDR_PULSE: begin
          data_nx       = data_out | wd;
          pulse_bits_nx = pulse_bits | wd;
          pulse_wd      = wd;
          pulse_cnt_nx  = PULSE_LOAD;
        end
        default: ;
      endcase
    end
    if (pulse_cnt == CNT_ONE) expire_clr = pulse_bits_nx & ~pulse_wd;
    data_nx       = data_nx & ~expire_clr;
    pulse_bits_nx = pulse_bits_nx & ~expire_clr;
    cap_nx        = (edge_cap & ~w1c) | detect;
  end

  always_comb begin
    rdata_nx = '0;
    if (rd) begin
      case (address)
        ADDR_DATA:    rdata_nx[WIDTH-1:0] = (dir & data_out) | (~dir & sync_in);
        ADDR_DIR:     rdata_nx[WIDTH-1:0] = dir;
        ADDR_IRQMASK: rdata_nx[WIDTH-1:0] = irq_mask;
        ADDR_EDGECAP: rdata_nx[WIDTH-1:0] = edge_cap;
        ADDR_PULSE:   rdata_nx[WIDTH-1:0] = pulse_bits;
        default:      rdata_nx = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= RESET_VALUE;
      dir        <= '0;
      irq_mask   <= '0;
      edge_cap   <= '0;
      pulse_bits <= '0;
      pulse_cnt  <= '0;
      sync_meta  <= '0;
      sync_in    <= '0;
      prev_in    <= '0;
      readdata   <= '0;
      irq        <= 1'b0;
    end else begin
      sync_meta  <= in_port;
      sync_in    <= sync_meta;
      prev_in    <= sync_in;
      data_out   <= data_nx;
      dir        <= dir_nx;
      irq_mask   <= mask_nx;
      edge_cap   <= cap_nx;
      pulse_bits <= pulse_bits_nx;
      pulse_cnt  <= pulse_cnt_nx;
      readdata   <= rdata_nx;
      irq        <= |(edge_cap & irq_mask);
    end
  end

endmodule

// File: tb/tb_pio_gpio_ctrl.sv
// Bench for pio_gpio_ctrl: directed scenarios with literal expectations, then
// randomized bus/pin traffic compared every cycle against a behavioural model.
module tb_pio_gpio_ctrl;

  localparam int         WIDTH     = 8;
  localparam logic [7:0] RV        = 8'hA5;
  localparam int         EDGE_TYPE = 0;
  localparam int         PL        = 4;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [7:0]  oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  pio_gpio_ctrl #(
    .WIDTH(WIDTH), .RESET_VALUE(RV), .EDGE_TYPE(EDGE_TYPE), .PULSE_LEN(PL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: pulses tracked by the absolute edge number at which they expire,
  // pin inputs by a short history of per-edge samples.
  logic [7:0]  m_data, m_dir, m_mask, m_cap, m_pb, m_irq_vec;
  logic        m_irq;
  logic [31:0] m_rdata;
  int          m_expire;
  int          m_cyc;
  logic [7:0]  hist[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_data = RV; m_dir = '0; m_mask = '0; m_cap = '0; m_pb = '0; m_irq_vec = '0;
    m_irq = 1'b0; m_rdata = '0; m_expire = -1; m_cyc = 0;
    hist.delete();
    repeat (3) hist.push_back(8'h00);
  endtask

  task automatic modelEdge();
    logic [7:0] s, p, det, wd, w1c, pwd, clr;
    logic       wr, rd;
    if (!reset_n) begin
      modelReset();
      return;
    end
    m_cyc++;
    s   = hist[1];
    p   = hist[0];
    wr  = chipselect && !write_n;
    rd  = chipselect && !read_n;
    wd  = writedata[7:0];
    w1c = '0;
    pwd = '0;
    case (EDGE_TYPE)
      0:       det = s & ~p;
      1:       det = ~s & p;
      default: det = s ^ p;
    endcase
    m_rdata = '0;
    if (rd) begin
      case (address)
        3'd0:    m_rdata = {24'h0, (m_dir & m_data) | (~m_dir & s)};
        3'd1:    m_rdata = {24'h0, m_dir};
        3'd2:    m_rdata = {24'h0, m_mask};
        3'd3:    m_rdata = {24'h0, m_cap};
        3'd6:    m_rdata = {24'h0, m_pb};
        default: m_rdata = '0;
      endcase
    end
    m_irq = |(m_cap & m_mask);
    clr = '0;
    if (wr) begin
      case (address)
        3'd0: begin m_data = wd; m_pb = '0; m_expire = -1; end
        3'd1: m_dir = wd;
        3'd2: m_mask = wd;
        3'd3: w1c = wd;
        3'd4: begin m_data = m_data | wd; m_pb = m_pb & ~wd; end
        3'd5: begin m_data = m_data & ~wd; m_pb = m_pb & ~wd; end
        3'd6: begin
          if (m_expire == m_cyc) clr = m_pb & ~wd;
          m_data = m_data | wd; m_pb = m_pb | wd; pwd = wd;
          m_expire = m_cyc + PL;
        end
        default: ;
      endcase
    end
    if (m_expire == m_cyc && pwd == '0 && !(wr && address == 3'd6)) clr = m_pb;
    m_data = m_data & ~clr;
    m_pb   = m_pb & ~clr;
    m_cap  = (m_cap & ~w1c) | det;
    hist.push_back(in_port);
    void'(hist.pop_front());
  endtask

  task automatic compareModel();
    checkOutput("model_out_port", {24'h0, out_port}, {24'h0, m_data});
    checkOutput("model_oe", {24'h0, oe}, {24'h0, m_dir});
    checkOutput("model_irq", {31'h0, irq}, {31'h0, m_irq});
    checkOutput("model_readdata", readdata, m_rdata);
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    compareModel();
  endtask

  task automatic applyStimulus(input logic cs, input logic wn, input logic rn,
                               input logic [2:0] addr, input logic [31:0] wdat);
    chipselect = cs; write_n = wn; read_n = rn; address = addr; writedata = wdat;
  endtask

  task automatic doWrite(input logic [2:0] addr, input logic [31:0] wdat);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, wdat);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 32'h0);
  endtask

  task automatic doRead(input logic [2:0] addr);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 32'h0);
  endtask

  initial begin
    int cnt;
    int r;
    reset_n = 1'b0;
    in_port = 8'h00;
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 32'h0);
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_out_port", {24'h0, out_port}, 32'hA5);
    checkOutput("reset_oe", {24'h0, oe}, 32'h00);
    checkOutput("reset_irq", {31'h0, irq}, 32'h0);
    checkOutput("reset_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    tick();

    doWrite(3'd0, 32'h3C);
    checkOutput("data_write", {24'h0, out_port}, 32'h3C);
    doWrite(3'd4, 32'h01);
    checkOutput("outset", {24'h0, out_port}, 32'h3D);
    doWrite(3'd5, 32'h0C);
    checkOutput("outclr", {24'h0, out_port}, 32'h31);
    doWrite(3'd4, 32'hFFFF_FF00);
    checkOutput("outset_high_bits_ignored", {24'h0, out_port}, 32'h31);
    doRead(3'd4);
    checkOutput("read_outset_zero", readdata, 32'h0);
    doRead(3'd5);
    checkOutput("read_outclr_zero", readdata, 32'h0);

    doWrite(3'd1, 32'hF0);
    doWrite(3'd0, 32'hAA);
    checkOutput("dir_oe", {24'h0, oe}, 32'hF0);
    in_port = 8'h0F;
    tick();
    tick();
    doRead(3'd0);
    checkOutput("read_data_mixed", readdata, 32'hAF);

    in_port = 8'h00;
    repeat (3) tick();
    doWrite(3'd3, 32'hFF);
    doWrite(3'd2, 32'h01);
    tick();
    in_port = 8'h01;
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 32'h0);
    tick();
    tick();
    tick();
    checkOutput("edgecap_before_3clk", readdata, 32'h00);
    checkOutput("irq_before_4clk", {31'h0, irq}, 32'h0);
    tick();
    checkOutput("edgecap_at_3clk", readdata, 32'h01);
    checkOutput("irq_at_4clk", {31'h0, irq}, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 32'h0);
    doWrite(3'd3, 32'h01);
    tick();
    checkOutput("irq_after_w1c", {31'h0, irq}, 32'h0);
    in_port = 8'h00;
    repeat (4) tick();
    in_port = 8'h01;
    tick();
    tick();
    doWrite(3'd3, 32'h01);
    doRead(3'd3);
    checkOutput("edge_set_beats_w1c", readdata, 32'h01);
    doWrite(3'd3, 32'hFF);
    tick();

    doWrite(3'd0, 32'h00);
    doWrite(3'd6, 32'h02);
    cnt = int'(out_port[1]);
    repeat (7) begin
      tick();
      cnt += int'(out_port[1]);
    end
    checkOutput("pulse_high_cycles", cnt, 32'd4);
    doWrite(3'd6, 32'h02);
    cnt = int'(out_port[1]);
    tick();
    cnt += int'(out_port[1]);
    doWrite(3'd6, 32'h02);
    cnt += int'(out_port[1]);
    repeat (8) begin
      tick();
      cnt += int'(out_port[1]);
    end
    checkOutput("pulse_restart_cycles", cnt, 32'd6);

    doWrite(3'd6, 32'h02);
    doWrite(3'd4, 32'h02);
    repeat (6) tick();
    checkOutput("outset_beats_expiry", {24'h0, out_port}, 32'h02);
    doWrite(3'd5, 32'h02);
    doWrite(3'd6, 32'h02);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_mid_pulse", {24'h0, out_port}, 32'hA5);
    checkOutput("async_reset_oe", {24'h0, oe}, 32'h00);
    modelReset();
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30)
        applyStimulus(1'b1, 1'b0, ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1,
                      3'($urandom_range(0, 7)), $urandom);
      else if (r < 60)
        applyStimulus(1'b1, 1'b1, 1'b0, 3'($urandom_range(0, 7)), $urandom);
      else
        applyStimulus(($urandom_range(0, 1) == 1), 1'b1, 1'b1, 3'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
